// File: rtl/loa_cla_pipe_locked_if.sv
// Operand/result stream bundle for the locked pipelined LOA adder.
// Both sides use valid/ready: a beat moves on a rising edge where valid and ready are both high.
interface loa_cla_pipe_locked_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH:0]   result_o;
    logic             out_valid_o;
    logic             out_ready_i;

    modport master (
        output add1_i, add2_i, in_valid_i, out_ready_i,
        input  in_ready_o, result_o, out_valid_o
    );

    modport slave (
        input  add1_i, add2_i, in_valid_i, out_ready_i,
        output in_ready_o, result_o, out_valid_o
    );
endinterface

// File: rtl/loa_cla_pipe_locked.sv
// Pipelined XOR-locked lower-part-OR adder: OR on the low LOWER bits, exact sum above,
// upper sum resolved one chunk per stage, key snapshot taken at accept.
module loa_cla_pipe_locked #(
    parameter int               WIDTH      = 32,
    parameter int               LOWER      = 8,
    parameter int               STAGES     = 2,
    parameter int               KEY_W      = 64,
    parameter logic [KEY_W-1:0] KEY_GOLDEN = 64'hF885B0E38EB7D380
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [KEY_W-1:0]      keyinput,
    input  logic                  key_load_i,
    loa_cla_pipe_locked_if.slave  bus
);
    localparam int U  = WIDTH - LOWER;
    localparam int CH = (U + STAGES - 1) / STAGES;
    localparam int UP = CH * STAGES;
    localparam int LW = (LOWER > 0) ? LOWER : 1;
    localparam int RW = WIDTH + 1;

    logic [STAGES-1:0] r_valid;
    logic [UP-1:0]     r_a   [STAGES];
    logic [UP-1:0]     r_b   [STAGES];
    logic [UP-1:0]     r_s   [STAGES];
    logic [STAGES-1:0] r_c;
    logic [LW-1:0]     r_lo  [STAGES];
    logic [KEY_W-1:0]  r_key [STAGES];
    logic [KEY_W-1:0]  r_key_q;
    logic [RW-1:0]     r_result;

    logic [STAGES-1:0] w_adv;
    logic [UP-1:0]     w_in_a   [STAGES];
    logic [UP-1:0]     w_in_b   [STAGES];
    logic [UP-1:0]     w_in_s   [STAGES];
    logic [UP-1:0]     w_s_nxt  [STAGES];
    logic [LW-1:0]     w_in_lo  [STAGES];
    logic [KEY_W-1:0]  w_in_key [STAGES];
    logic [CH:0]       w_chunk  [STAGES];
    logic [STAGES-1:0] w_in_c;
    logic [STAGES-1:0] w_in_v;
    logic [STAGES-1:0] w_c_nxt;
    logic [LW-1:0]     w_lo0;
    logic              w_cin0;
    logic [UP:0]       w_full;
    logic [RW-1:0]     w_raw;
    logic [RW-1:0]     w_res;

    // Key bit i lands on result bit i mod (WIDTH+1).
    function automatic logic [RW-1:0] fold_key(input logic [KEY_W-1:0] d);
        logic [RW-1:0] m;
        m = '0;
        for (int i = 0; i < KEY_W; i++) m[i % RW] = m[i % RW] ^ d[i];
        return m;
    endfunction

    generate
        if (LOWER > 0) begin : g_lower
            assign w_lo0  = bus.add1_i[LOWER-1:0] | bus.add2_i[LOWER-1:0];
            assign w_cin0 = bus.add1_i[LOWER-1] & bus.add2_i[LOWER-1];
        end else begin : g_exact
            assign w_lo0  = '0;
            assign w_cin0 = 1'b0;
        end
    endgenerate

    // A stage can take a new beat unless it and every stage after it is full and blocked.
    always_comb begin
        w_adv = '0;
        for (int s = 0; s < STAGES; s++)
            w_adv[s] = bus.out_ready_i | (((~r_valid) >> s) != '0);
    end

    always_comb begin
        w_in_c = '0;
        w_in_v = '0;
        w_c_nxt = '0;
        w_in_a[0]   = UP'(bus.add1_i[WIDTH-1:LOWER]);
        w_in_b[0]   = UP'(bus.add2_i[WIDTH-1:LOWER]);
        w_in_s[0]   = '0;
        w_in_c[0]   = w_cin0;
        w_in_v[0]   = bus.in_valid_i;
        w_in_lo[0]  = w_lo0;
        w_in_key[0] = r_key_q;
        for (int s = 1; s < STAGES; s++) begin
            w_in_a[s]   = r_a[s-1];
            w_in_b[s]   = r_b[s-1];
            w_in_s[s]   = r_s[s-1];
            w_in_c[s]   = r_c[s-1];
            w_in_v[s]   = r_valid[s-1];
            w_in_lo[s]  = r_lo[s-1];
            w_in_key[s] = r_key[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            w_chunk[s] = {1'b0, w_in_a[s][s*CH +: CH]} + {1'b0, w_in_b[s][s*CH +: CH]}
                       + {{CH{1'b0}}, w_in_c[s]};
            w_s_nxt[s] = w_in_s[s];
            w_s_nxt[s][s*CH +: CH] = w_chunk[s][CH-1:0];
            w_c_nxt[s] = w_chunk[s][CH];
        end
        // Operands are zero-padded to UP bits, so the true carry-out sits at bit U.
        w_full = {w_c_nxt[STAGES-1], w_s_nxt[STAGES-1]};
        w_raw  = (RW'(w_full[U:0]) << LOWER) | RW'(w_in_lo[STAGES-1]);
        w_res  = w_raw ^ fold_key(w_in_key[STAGES-1] ^ KEY_GOLDEN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid  <= '0;
            r_c      <= '0;
            r_key_q  <= '0;
            r_result <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_s[s]   <= '0;
                r_lo[s]  <= '0;
                r_key[s] <= '0;
            end
        end else begin
            if (key_load_i) r_key_q <= keyinput;
            for (int s = 0; s < STAGES; s++) begin
                if (w_adv[s]) begin
                    r_valid[s] <= w_in_v[s];
                    if (w_in_v[s]) begin
                        if (s == STAGES - 1) begin
                            r_result <= w_res;
                        end else begin
                            r_a[s]   <= w_in_a[s];
                            r_b[s]   <= w_in_b[s];
                            r_s[s]   <= w_s_nxt[s];
                            r_c[s]   <= w_c_nxt[s];
                            r_lo[s]  <= w_in_lo[s];
                            r_key[s] <= w_in_key[s];
                        end
                    end
                end
            end
        end
    end

    assign bus.in_ready_o  = w_adv[0];
    assign bus.out_valid_o = r_valid[STAGES-1];
    assign bus.result_o    = r_result;
endmodule
